// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, buffered entry layout,
// and the opcode values the decoder also depends on.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int INSTR_W     = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-register FIFO: slot 0 is always the head, so the head is a plain
// register. Slots at or above count are kept at zero.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] wr_idx;

   // With a simultaneous pop the new entry lands one slot lower.
   assign wr_idx = count_reg - CW'(pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : gen_slot
         logic [WIDTH-1:0] slot_reg;
         logic [WIDTH-1:0] shift_in;

         if (gi == DEPTH - 1) begin : gen_top
            assign shift_in = '0;
         end else begin : gen_mid
            assign shift_in = gen_slot[gi+1].slot_reg;
         end

         always_ff @(posedge clk) begin
            if (srst || flush) begin
               slot_reg <= '0;
            end else if (push && (wr_idx == CW'(gi))) begin
               slot_reg <= push_data;
            end else if (pop) begin
               slot_reg <= shift_in;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   assign count = count_reg;
   assign head  = gen_slot[0].slot_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: req/ack memory side, small buffer, valid/ready decode side.
// Optional misaligned-redirect trap (HALT state, o_misalign) under FETCH_MISALIGN_TRAP_EN.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ack,
   input  logic [31:0]     i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_instr_valid,
   input  logic            i_instr_ready,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   output logic [6:0]      o_opcode
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            o_misalign
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = XLEN + INSTR_W;

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [XLEN-1:0] target_reg, target_next;
   logic            req_reg, req_next;

   logic            push, pop;
   logic [CW-1:0]   fifo_count, count_next;
   logic [EW-1:0]   fifo_head;
   logic            head_valid;

   logic            ack_eff, hold;
   logic [XLEN-1:0] redir_eff, landing_pc;
   logic            redir_bad, target_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redir_eff  = i_redirect_pc;
   assign redir_bad  = |i_redirect_pc[1:0];
   assign target_bad = |target_reg[1:0];
`else
   assign redir_eff  = i_redirect_pc & ~XLEN'(3);
   assign redir_bad  = 1'b0;
   assign target_bad = 1'b0;
`endif

   assign ack_eff    = req_reg & i_imem_ack;
   assign hold       = req_reg & ~i_imem_ack;
   assign head_valid = (fifo_count != '0);
   // A redirect cycle never consumes the (wrong-path) head.
   assign pop        = head_valid & i_instr_ready & ~i_redirect;

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      target_next = target_reg;
      push        = 1'b0;
      landing_pc  = target_reg;

      case (state_reg)
         FETCH: begin
            if (i_redirect) begin
               if (hold) begin
                  state_next  = FLUSH;
                  target_next = redir_eff;
               end else begin
                  pc_next    = redir_eff;
                  state_next = redir_bad ? HALT : FETCH;
               end
            end else if (ack_eff) begin
               push    = 1'b1;
               pc_next = pc_reg + XLEN'(INSTR_BYTES);
            end
         end
         FLUSH: begin
            if (i_redirect) begin
               target_next = redir_eff;
               landing_pc  = redir_eff;
            end
            if (ack_eff) begin
               pc_next    = landing_pc;
               state_next = (i_redirect ? redir_bad : target_bad) ? HALT : FETCH;
            end
         end
         HALT: begin
            if (i_redirect) begin
               pc_next    = redir_eff;
               state_next = redir_bad ? HALT : FETCH;
            end
         end
         default: state_next = FETCH;
      endcase

      count_next = fifo_count + CW'(push) - CW'(pop);
      if (i_redirect) begin
         count_next = '0;
      end
      // Credit rule: only request when the returning word is guaranteed a slot.
      req_next = hold | ((state_next == FETCH) && (count_next < CW'(FIFO_DEPTH)));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg  <= FETCH;
         pc_reg     <= RESET_PC;
         target_reg <= RESET_PC;
         req_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         target_reg <= target_next;
         req_reg    <= req_next;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .srst      (i_rst),
      .push      (push),
      .pop       (pop),
      .flush     (i_redirect),
      .push_data ({pc_reg, i_imem_rdata}),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign o_imem_req    = req_reg;
   assign o_imem_addr   = pc_reg;
   assign o_instr_valid = head_valid;
   assign o_instr       = head_valid ? fifo_head[INSTR_W-1:0] : '0;
   assign o_instr_pc    = head_valid ? fifo_head[EW-1:INSTR_W] : '0;
   assign o_opcode      = head_valid ? fifo_head[6:0] : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign o_misalign = (state_reg == HALT);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder with configurable ack delay,
// scoreboard of expected {pc, instr} checked at each decode pop. Honors FETCH_MISALIGN_TRAP_EN.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic        o_instr_valid;
   logic        i_instr_ready = 1'b0;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic [6:0]  o_opcode;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        o_misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int mem_delay = 0;
   int ack_count = 0;

   fetch_entry_t sb[$];
   logic [31:0]  exp_pc = '0;
   logic [31:0]  latched = '0;
   bit           flushing = 1'b0;
   logic         prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
   logic [31:0]  prev_addr = '0;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rdata  (i_imem_rdata),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_instr_valid (o_instr_valid),
      .i_instr_ready (i_instr_ready),
      .o_instr       (o_instr),
      .o_instr_pc    (o_instr_pc),
      .o_opcode      (o_opcode)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .o_misalign    (o_misalign)
`endif
   );

   initial forever #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      logic [6:0] opc;
      case (addr[3:2])
         2'd0:    opc = OPC_LOAD;
         2'd1:    opc = OPC_STORE;
         2'd2:    opc = OPC_BRANCH;
         default: opc = OPC_OP;
      endcase
      return {addr[26:2], opc};
   endfunction

   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_redirect = 1'b0;
      repeat (2) step();
      check("rst_req", o_imem_req, 0);
      check("rst_addr", o_imem_addr, 32'h0);
      check("rst_valid", o_instr_valid, 0);
      check("rst_instr", o_instr, 0);
      check("rst_pc", o_instr_pc, 0);
      check("rst_opcode", o_opcode, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misalign", o_misalign, 0);
`endif
      i_rst = 1'b0;
   endtask

   // Memory responder: acks after mem_delay idle cycles of an asserted request.
   initial begin
      int wait_cnt = 0;
      forever begin
         @(posedge i_clk);
         #1;
         if (o_imem_req) begin
            if (wait_cnt >= mem_delay) begin
               i_imem_ack   = 1'b1;
               i_imem_rdata = mem_word(o_imem_addr);
               wait_cnt     = 0;
            end else begin
               i_imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            i_imem_ack = 1'b0;
            wait_cnt   = 0;
         end
      end
   end

   // Monitor / scoreboard, evaluated mid-cycle for the coming edge.
   always @(negedge i_clk) begin
      fetch_entry_t e;
      logic [31:0]  tgt;
      if (i_rst) begin
         sb.delete();
         exp_pc    = 32'h0;
         flushing  = 1'b0;
         ack_count = 0;
      end else begin
         if (!prev_rst && prev_req && !prev_ack) begin
            check("req_hold", o_imem_req, 1);
            check("addr_hold", o_imem_addr, prev_addr);
         end
         if (o_instr_valid && i_instr_ready && !i_redirect) begin
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               $display("pop pc=0x%08h instr=0x%08h", o_instr_pc, o_instr);
               check("pop_pc", o_instr_pc, e.pc);
               check("pop_instr", o_instr, e.instr);
               check("pop_opcode", o_opcode, e.instr[6:0]);
            end
         end
         if (o_imem_req && i_imem_ack) begin
            ack_count++;
            check("ack_addr", o_imem_addr, exp_pc);
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         tgt = i_redirect_pc;
`else
         tgt = i_redirect_pc & ~32'h3;
`endif
         if (i_redirect) begin
            sb.delete();
            if (flushing) begin
               latched = tgt;
               if (o_imem_req && i_imem_ack) begin
                  exp_pc   = tgt;
                  flushing = 1'b0;
               end
            end else if (o_imem_req && !i_imem_ack) begin
               flushing = 1'b1;
               latched  = tgt;
            end else begin
               exp_pc = tgt;
            end
         end else if (o_imem_req && i_imem_ack) begin
            if (flushing) begin
               exp_pc   = latched;
               flushing = 1'b0;
            end else begin
               e.pc    = exp_pc;
               e.instr = mem_word(exp_pc);
               sb.push_back(e);
               exp_pc  = exp_pc + 32'd4;
            end
         end
      end
      prev_req  = o_imem_req;
      prev_ack  = i_imem_ack;
      prev_rst  = i_rst;
      prev_addr = o_imem_addr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      bit found;

      // Streaming: ack every cycle, ready every cycle.
      mem_delay = 0;
      i_instr_ready = 1'b1;
      do_reset();
      step();
      check("a_req0", o_imem_req, 1);
      check("a_addr0", o_imem_addr, 32'h0);
      step();
      w = mem_word(32'h0);
      check("a_addr4", o_imem_addr, 32'h4);
      check("a_valid", o_instr_valid, 1);
      check("a_pc0", o_instr_pc, 32'h0);
      check("a_opc0", o_opcode, w[6:0]);
      step();
      check("a_addr8", o_imem_addr, 32'h8);
      check("a_pc4", o_instr_pc, 32'h4);
      step();
      w = mem_word(32'h8);
      check("a_pc8", o_instr_pc, 32'h8);
      check("a_opc8", o_opcode, w[6:0]);
`ifndef FETCH_MISALIGN_TRAP_EN
      i_redirect = 1'b1;
      i_redirect_pc = 32'h106;
      step();
      i_redirect = 1'b0;
      check("a_lowbits_addr", o_imem_addr, 32'h104);
      check("a_lowbits_valid", o_instr_valid, 0);
`endif

      // Backpressure: ready low, credit limit stops requests after two pushes.
      i_instr_ready = 1'b0;
      do_reset();
      repeat (6) step();
      check("b_acks", ack_count, 2);
      check("b_req_off", o_imem_req, 0);
      check("b_head", o_instr_pc, 32'h0);
      i_instr_ready = 1'b1;
      step();
      i_instr_ready = 1'b0;
      check("b_req_on", o_imem_req, 1);
      check("b_addr8", o_imem_addr, 32'h8);
      check("b_head4", o_instr_pc, 32'h4);

      // Redirect while a delayed request is outstanding.
      do_reset();
      repeat (6) step();
      mem_delay = 3;
      i_instr_ready = 1'b1;
      step();
      check("c_req", o_imem_req, 1);
      check("c_addr8", o_imem_addr, 32'h8);
      check("c_pending", i_imem_ack, 0);
      check("c_head4", o_instr_pc, 32'h4);
      i_redirect = 1'b1;
      i_redirect_pc = 32'h100;
      step();
      i_redirect = 1'b0;
      check("c_valid_off", o_instr_valid, 0);
      check("c_addr_held", o_imem_addr, 32'h8);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (o_imem_req && i_imem_ack) found = 1'b1;
         else step();
      end
      check("c_ack_seen", found, 1);
      check("c_ack_addr", o_imem_addr, 32'h8);
      step();
      check("c_req100", o_imem_req, 1);
      check("c_addr100", o_imem_addr, 32'h100);
      check("c_discard", o_instr_valid, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (o_instr_valid) found = 1'b1;
      end
      check("c_valid_seen", found, 1);
      check("c_head100", o_instr_pc, 32'h100);

      // Redirect coincident with ack, then a second redirect during FLUSH.
      i_instr_ready = 1'b0;
      mem_delay = 2;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (o_imem_req && i_imem_ack) found = 1'b1;
      end
      check("d_ack_seen", found, 1);
      check("d_ack_addr0", o_imem_addr, 32'h0);
      i_redirect = 1'b1;
      i_redirect_pc = 32'h200;
      step();
      i_redirect = 1'b0;
      check("d_addr200", o_imem_addr, 32'h200);
      check("d_empty", o_instr_valid, 0);
      check("d_noack", i_imem_ack, 0);
      i_redirect = 1'b1;
      i_redirect_pc = 32'h280;
      step();
      i_redirect_pc = 32'h300;
      check("d_flush_req", o_imem_req, 1);
      check("d_flush_addr", o_imem_addr, 32'h200);
      check("d_flush_noack", i_imem_ack, 0);
      step();
      i_redirect = 1'b0;
      step();
      check("d_req300", o_imem_req, 1);
      check("d_addr300", o_imem_addr, 32'h300);
      check("d_empty2", o_instr_valid, 0);

      // Reset while a request is pending.
      mem_delay = 3;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (o_instr_valid) found = 1'b1;
      end
      check("e_valid_seen", found, 1);
      check("e_pending", o_imem_req, 1);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      check("e_req_drop", o_imem_req, 0);
      check("e_valid_drop", o_instr_valid, 0);
      step();
      check("e_restart_req", o_imem_req, 1);
      check("e_restart_addr", o_imem_addr, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
      // Misaligned redirect traps; an aligned redirect resumes.
      mem_delay = 0;
      i_instr_ready = 1'b1;
      do_reset();
      repeat (3) step();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h102;
      step();
      i_redirect = 1'b0;
      check("f_misalign", o_misalign, 1);
      check("f_valid", o_instr_valid, 0);
      for (int i = 0; i < 3; i++) begin
         check("f_noreq", o_imem_req, 0);
         step();
      end
      i_redirect = 1'b1;
      i_redirect_pc = 32'h104;
      step();
      i_redirect = 1'b0;
      check("f_clear", o_misalign, 0);
      check("f_req", o_imem_req, 1);
      check("f_addr", o_imem_addr, 32'h104);
`endif

      i_instr_ready = 1'b1;
      repeat (5) step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
